fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter: DWID, default 16, data word width in bits.
REQ-002 Parameter: BLEN, default 4, output beats per frame; legal range 2 to 256.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 fifo_empty_i  input  1  source FIFO empty flag.
REQ-006 fifo_rdata_i  input  DWID  source FIFO head word; valid in the same cycle whenever fifo_empty_i=0.
REQ-007 fifo_rd_o  output  1  pop strobe to the source FIFO; the head word is consumed at the same clock edge.
REQ-008 flush_i  input  1  synchronous flush of buffered data and frame position.
REQ-009 m_valid_o  output  1  output stream word valid.
REQ-010 m_ready_i  input  1  downstream accepts the word.
REQ-011 m_data_o  output  DWID  output stream data.
REQ-012 m_sop_o  output  1  first beat of a frame.
REQ-013 m_eop_o  output  1  last beat of a frame.

Function
REQ-014 The block SHALL hold a 2-entry buffer whose occupancy FSM has states EMPTY (0 words), HALF (1 word) and FULL (2 words).
REQ-015 fifo_rd_o SHALL be combinational: it equals ~fifo_empty_i AND state!=FULL AND ~flush_i.
REQ-016 When fifo_rd_o=1, fifo_rdata_i SHALL be written into the buffer at that clock edge.
REQ-017 m_valid_o SHALL be 1 exactly when state!=EMPTY, and m_data_o SHALL be the oldest buffered word.
REQ-018 A pop SHALL occur on any cycle with m_valid_o=1 and m_ready_i=1; the next buffered word, if any, SHALL be presented in the following cycle.
REQ-019 Transitions: EMPTY→HALF on a push; HALF→FULL on a push without a pop; HALF→EMPTY on a pop without a push; HALF stays HALF on a simultaneous push and pop; FULL→HALF on a pop; all other cases hold the state.
REQ-020 Latency: a word at the FIFO head while state=EMPTY SHALL appear on m_data_o with m_valid_o=1 exactly 1 cycle later.
REQ-021 Throughput: with the FIFO non-empty and m_ready_i held at 1, the block SHALL deliver 1 word per cycle indefinitely.
REQ-022 When m_valid_o=1 and m_ready_i=0, m_data_o, m_sop_o and m_eop_o SHALL remain stable until the pop.
REQ-023 Word order SHALL be preserved; no word is dropped or duplicated except by flush_i.
REQ-024 A beat counter of width $clog2(BLEN) SHALL increment on each pop and wrap from BLEN-1 to 0.
REQ-025 m_sop_o SHALL equal m_valid_o AND (beat counter==0).
REQ-026 m_eop_o SHALL equal m_valid_o AND (beat counter==BLEN-1).
REQ-027 When flush_i=1 at a clock edge, the block SHALL:
  - discard both buffer entries and go to EMPTY;
  - reset the beat counter to 0;
  - perform no FIFO pop in that cycle.
  Flush takes priority over any push or pop in the same cycle.
REQ-028 The pop qualified by m_ready_i in a flush cycle SHALL NOT be counted as a delivered beat.
REQ-029 When fifo_empty_i=1, fifo_rd_o SHALL be 0 regardless of the other inputs.

Reset
REQ-030 While rst=0: state=EMPTY, beat counter=0, and fifo_rd_o is forced to 0.
REQ-031 m_valid_o, m_sop_o and m_eop_o SHALL be 0 while rst=0; m_data_o SHALL be 0 while rst=0.
REQ-032 Assertion of rst mid-frame or mid-transfer SHALL immediately discard buffered data and frame position.
REQ-033 Operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-034 Scenario: FIFO holds 0x0001..0x0008, m_ready_i=1 → 8 consecutive valid beats 0x0001..0x0008; sop on beats 1 and 5; eop on beats 4 and 8; first beat 1 cycle after the first fifo_rd_o.
REQ-035 Scenario: m_ready_i=0 with FIFO non-empty → exactly 2 pops, then fifo_rd_o=0 with state FULL; raise m_ready_i → words emerge in order with no loss.
REQ-036 Scenario: m_ready_i toggling 1/0 every cycle, 12 words → all 12 words in order; data stable during stalls; sop/eop every 4 accepted beats.
REQ-037 Scenario: flush_i pulse after beat 2 of a frame with state FULL → m_valid_o=0 next cycle; no pop in the flush cycle; the next accepted word carries m_sop_o=1.
REQ-038 Scenario: fifo_empty_i=1 throughout → fifo_rd_o=0 and m_valid_o=0 for all cycles.
REQ-039 Scenario: rst=0 asserted asynchronously between clock edges mid-frame → all outputs 0 immediately; after release the first word delivered has m_sop_o=1.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Pulls words from a show-ahead FIFO into a 2-entry skid buffer and
// streams them out valid/ready with per-frame sop/eop markers.
module fifo_stream_reader #(
  parameter int DWID = 16,
  parameter int BLEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_empty_i,
  input  logic [DWID-1:0] fifo_rdata_i,
  output logic            fifo_rd_o,
  input  logic            flush_i,
  output logic            m_valid_o,
  input  logic            m_ready_i,
  output logic [DWID-1:0] m_data_o,
  output logic            m_sop_o,
  output logic            m_eop_o
);

  localparam int CW = $clog2(BLEN);
  localparam logic [CW-1:0] LAST = CW'(BLEN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_nx;
  logic [DWID-1:0] buf0_q, buf0_nx;
  logic [DWID-1:0] buf1_q, buf1_nx;
  logic [CW-1:0]   cnt_q, cnt_nx;
  logic            push, pop;

  assign fifo_rd_o = rst & ~fifo_empty_i
                   & (state_q != FULL) & ~flush_i;
  assign push = fifo_rd_o;
  assign pop  = m_valid_o & m_ready_i & ~flush_i;

  assign m_valid_o = (state_q != EMPTY);
  assign m_data_o  = buf0_q;
  assign m_sop_o   = m_valid_o & (cnt_q == '0);
  assign m_eop_o   = m_valid_o & (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      buf0_q  <= '0;
      buf1_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      buf0_q  <= buf0_nx;
      buf1_q  <= buf1_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    buf0_nx  = buf0_q;
    buf1_nx  = buf1_q;
    cnt_nx   = cnt_q;
    if (flush_i) begin
      state_nx = EMPTY;
      cnt_nx   = '0;
    end else begin
      if (pop) begin
        cnt_nx = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            buf0_nx  = fifo_rdata_i;
            state_nx = HALF;
          end
        end
        HALF: begin
          if (push && pop) begin
            buf0_nx = fifo_rdata_i;
          end else if (push) begin
            buf1_nx  = fifo_rdata_i;
            state_nx = FULL;
          end else if (pop) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            buf0_nx  = buf1_q;
            state_nx = HALF;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: directed scenarios plus random traffic,
// checked against a queue-based model of the buffer and frame position.
module tb_fifo_stream_reader;

  localparam int DWID = 16;
  localparam int BLEN = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            fifo_empty_i;
  logic [DWID-1:0] fifo_rdata_i;
  logic            fifo_rd_o;
  logic            flush_i;
  logic            m_valid_o;
  logic            m_ready_i;
  logic [DWID-1:0] m_data_o;
  logic            m_sop_o;
  logic            m_eop_o;

  int checks = 0;
  int failures = 0;

  logic [DWID-1:0] src[$];
  logic [DWID-1:0] bq[$];
  int              beat = 0;
  logic [DWID-1:0] next_word = 16'h0001;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DWID(DWID), .BLEN(BLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rd_o    (fifo_rd_o),
    .flush_i      (flush_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_sop_o      (m_sop_o),
    .m_eop_o      (m_eop_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      src.push_back(next_word);
      next_word = next_word + 1'b1;
    end
  endtask

  // One clock cycle: drive, check against the model, then advance it.
  task automatic step(input logic rdy, input logic fl,
                      input logic hold_empty);
    logic e_empty, e_rd, e_valid, e_pop;
    m_ready_i    = rdy;
    flush_i      = fl;
    e_empty      = hold_empty || (src.size() == 0);
    fifo_empty_i = e_empty;
    fifo_rdata_i = (src.size() != 0) ? src[0] : '0;
    #1;
    e_valid = (bq.size() != 0);
    e_rd    = !e_empty && (bq.size() < 2) && !fl;
    chk("rd", 32'(fifo_rd_o), 32'(e_rd));
    chk("valid", 32'(m_valid_o), 32'(e_valid));
    if (e_valid) begin
      chk("data", 32'(m_data_o), 32'(bq[0]));
      chk("sop", 32'(m_sop_o), 32'(beat == 0));
      chk("eop", 32'(m_eop_o), 32'(beat == BLEN - 1));
    end else begin
      chk("sop_idle", 32'(m_sop_o), 32'(0));
      chk("eop_idle", 32'(m_eop_o), 32'(0));
    end
    @(posedge clk);
    if (fl) begin
      bq.delete();
      beat = 0;
    end else begin
      e_pop = e_valid && rdy;
      if (e_pop) begin
        void'(bq.pop_front());
        beat = (beat + 1) % BLEN;
      end
      if (e_rd) bq.push_back(src.pop_front());
    end
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd"}, 32'(fifo_rd_o), 32'(0));
    chk({tag, "_valid"}, 32'(m_valid_o), 32'(0));
    chk({tag, "_sop"}, 32'(m_sop_o), 32'(0));
    chk({tag, "_eop"}, 32'(m_eop_o), 32'(0));
    chk({tag, "_data"}, 32'(m_data_o), 32'(0));
  endtask

  initial begin
    rst          = 1'b0;
    m_ready_i    = 1'b1;
    flush_i      = 1'b0;
    fifo_empty_i = 1'b0;
    fifo_rdata_i = 16'hbeef;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Straight run of 8 words, ready high
    load(8);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0);

    // Stalled sink: buffer fills after 2 pops, then drains in order
    load(6);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);

    // Ready toggling every cycle over 12 words
    load(12);
    for (int i = 0; i < 30; i++) step(1'(i % 2 == 0), 1'b0, 1'b0);

    // Flush after beat 2 with buffer full
    step(1'b0, 1'b1, 1'b1);
    load(8);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);

    // Source empty throughout
    load(3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);

    // Async reset mid-frame, between clock edges
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    load(6);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    bq.delete();
    beat = 0;
    @(posedge clk);
    #2;
    chk_reset_outs("rst_hold");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) load($urandom_range(1, 4));
      step(1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
